uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: GAP_CYCLES, 2, idle cycles inserted between one frame's done and the next launch (0..15).
REQ-002 Parameter: TIMEOUT_CYCLES, 256, WAIT_DONE cycles before abort (range 16..65535).
REQ-003 Port: i_Clock  in  1  single clock; all logic on posedge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: i_req_valid  in  2  per-requester frame request; bit k is requester k.
REQ-006 Port: i_req0_byte, i_req1_byte  in  8 each  payload per requester.
REQ-007 Port: i_req_pen, i_req_eps  in  2 each  per-requester parity enable / even-parity select.
REQ-008 Port: o_req_ready  out  2  one-cycle acceptance pulse per requester.
REQ-009 Port: o_start_transmission  out  1  start pulse to the UART transmitter.
REQ-010 Port: o_Tx_Byte  out  8; o_pen, o_eps  out  1 each  frame payload and parity config to the transmitter.
REQ-011 Port: i_Tx_Busy, i_Tx_Done  in  1 each  transmitter status.
REQ-012 Port: o_grant  out  2  one-hot owner of the current frame; 0 when idle.
REQ-013 Port: o_timeout  out  1  one-cycle pulse on watchdog abort.
REQ-014 Port: o_frames_sent  out  16  count of frames completed with done.

Function
REQ-015 States: IDLE, LAUNCH, WAIT_DONE, GAP; all outputs registered.
REQ-016 IDLE: any i_req_valid bit set -> select winner, capture its byte/pen/eps into holding registers, go LAUNCH; otherwise stay.
REQ-017 Arbitration: round-robin; single request wins; both requests -> winner is the requester not granted last; last-grant pointer updates only on acceptance.
REQ-018 LAUNCH (exactly one cycle): o_start_transmission=1, o_req_ready[winner]=1, o_grant=one-hot winner; next state WAIT_DONE.
REQ-019 Acceptance latency: valid sampled at edge N in IDLE -> ready and start high during cycle N+1.
REQ-020 o_Tx_Byte, o_pen, o_eps SHALL hold the captured values unchanged from LAUNCH through WAIT_DONE exit (transmitter latches byte late and computes parity at end of data).
REQ-021 o_start_transmission SHALL be 0 in every state except LAUNCH (prevents transmitter back-to-back restart from its stop state).
REQ-022 WAIT_DONE: i_Tx_Done=1 -> increment o_frames_sent (wraps 0xFFFF->0x0000), clear o_grant, go GAP (or IDLE when GAP_CYCLES=0); i_Tx_Busy is informational only.
REQ-023 WAIT_DONE watchdog: counter cleared on LAUNCH; reaching TIMEOUT_CYCLES without done -> o_timeout pulse, clear o_grant, go IDLE, o_frames_sent unchanged.
REQ-024 GAP: count GAP_CYCLES cycles, then IDLE; requests arriving during LAUNCH/WAIT_DONE/GAP are held by the requester (valid stays high until ready) and are not accepted.
REQ-025 A requester that drops valid before ready forfeits; no ready is issued to it.
REQ-026 Done and watchdog expiry in the same cycle -> done wins (count increments, no o_timeout).

Reset
REQ-027 rst=1 at a posedge: state IDLE, o_start_transmission=0, o_req_ready=0, o_grant=0, o_timeout=0, o_frames_sent=0, o_Tx_Byte=0, o_pen=0, o_eps=0, counters 0, last-grant pointer favors requester 0 next.
REQ-028 Reset mid-frame SHALL abandon the frame with no ready/timeout pulse; rst has priority over all transitions.

Structure
REQ-029 Shared package holds: state encoding constants, requester count (2), and GAP/timeout counter widths.
REQ-030 One sub-module: uart_rr_arbiter2 (2-way round-robin with pointer and update enable); the rest is a single FSM.

Verification
REQ-031 Single: req0 valid with byte 0x4A, pen=0 -> ready[0] and start high same cycle N+1, o_Tx_Byte=0x4A stable until done, o_frames_sent=1.
REQ-032 Contention: both valid continuously, bytes 0xAE/0xFF -> grants alternate 0,1,0,1 over four frames; each requester gets two readys.
REQ-033 Parity config: req1 byte 0xFF, pen=1, eps=1 -> o_pen=1, o_eps=1 held through frame; transmitter serial shows parity bit 0.
REQ-034 Gap: GAP_CYCLES=2, back-to-back req0 -> exactly 2 cycles between done sample and next LAUNCH start pulse.
REQ-035 Watchdog: TIMEOUT_CYCLES=16, done tied 0 -> o_timeout pulses 16 cycles after LAUNCH, state IDLE, count unchanged.
REQ-036 Reset mid-frame: rst during WAIT_DONE -> next cycle all outputs at reset values; new req0 afterwards wins even if req1 also valid.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// FSM state encoding, requester count and watchdog/gap counter widths.
package uart_tx_arbiter_pkg;

  localparam int NUM_REQ   = 2;
  localparam int GAP_CNT_W = 4;
  localparam int TMO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Two-way round-robin arbiter: combinational grant from the live requests,
// with a last-winner pointer that only advances when the grant is taken.
module uart_rr_arbiter2
  import uart_tx_arbiter_pkg::*;
(
  input  logic               i_Clock,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant
);

  // Set when requester 1 won most recently; reset to 1 so requester 0 goes first.
  logic last_grant;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update && (grant != '0)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two requesters: round-robin pick,
// one-cycle launch, wait for done with a watchdog, then an optional idle gap.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_Clock,
  input  logic        rst,
  input  logic [1:0]  i_req_valid,
  input  logic [7:0]  i_req0_byte,
  input  logic [7:0]  i_req1_byte,
  input  logic [1:0]  i_req_pen,
  input  logic [1:0]  i_req_eps,
  output logic [1:0]  o_req_ready,
  output logic        o_start_transmission,
  output logic [7:0]  o_Tx_Byte,
  output logic        o_pen,
  output logic        o_eps,
  input  logic        i_Tx_Busy,
  input  logic        i_Tx_Done,
  output logic [1:0]  o_grant,
  output logic        o_timeout,
  output logic [15:0] o_frames_sent
);

  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [TMO_CNT_W-1:0] wd_cnt;
  logic [1:0]           win;
  logic                 accept;
  logic                 unused_busy;

  // Transmitter busy is status only; completion is signalled by done alone.
  assign unused_busy = i_Tx_Busy;

  assign accept = (state == IDLE) && (i_req_valid != '0);

  uart_rr_arbiter2 u_arb (
    .i_Clock (i_Clock),
    .rst     (rst),
    .req     (i_req_valid),
    .update  (accept),
    .grant   (win)
  );

  always_ff @(posedge i_Clock) begin
    if (rst) begin
      state                <= IDLE;
      gap_cnt              <= '0;
      wd_cnt               <= '0;
      o_req_ready          <= '0;
      o_start_transmission <= 1'b0;
      o_Tx_Byte            <= '0;
      o_pen                <= 1'b0;
      o_eps                <= 1'b0;
      o_grant              <= '0;
      o_timeout            <= 1'b0;
      o_frames_sent        <= '0;
    end else begin
      o_start_transmission <= 1'b0;
      o_req_ready          <= '0;
      o_timeout            <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state                <= LAUNCH;
            o_start_transmission <= 1'b1;
            o_req_ready          <= win;
            o_grant              <= win;
            o_Tx_Byte            <= win[1] ? i_req1_byte  : i_req0_byte;
            o_pen                <= win[1] ? i_req_pen[1] : i_req_pen[0];
            o_eps                <= win[1] ? i_req_eps[1] : i_req_eps[0];
          end
        end
        LAUNCH: begin
          state  <= WAIT_DONE;
          wd_cnt <= '0;
        end
        WAIT_DONE: begin
          // Done is tested first so it wins over a watchdog expiry in the same cycle.
          if (i_Tx_Done) begin
            o_frames_sent <= o_frames_sent + 16'd1;
            o_grant       <= '0;
            gap_cnt       <= '0;
            state         <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (wd_cnt == TMO_LAST) begin
            o_timeout <= 1'b1;
            o_grant   <= '0;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + TMO_CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
